// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
//   requesters in the wr_clk domain. A grant lasts up to MAX_BURST beats and
//   costs one idle bubble cycle for arbitration. FIFO full backpressures the
//   current owner through req_ready; a beat moves only on valid & ready.
//
// Ports
//   wr_clk, rst_n   clock, async active-low reset
//   req_valid       per-requester beat valid            [NUM_REQ]
//   req_data        requester i beat at [i*W +: W]      [NUM_REQ*W]
//   req_ready       per-requester accept (owner only)   [NUM_REQ]
//   fifo_wr_en      FIFO write enable (= accepted beat)
//   fifo_din        FIFO write data (owner's beat)      [W]
//   fifo_full       FIFO full flag
//   grant_id        current / last owner index
//   busy            1 while a grant is active
//   stats_clr       sync clear of stall_cnt             (FIFO_ARB_STATS_EN)
//   stall_cnt       saturating count of stalled cycles  (FIFO_ARB_STATS_EN)
//
// Build option: define FIFO_ARB_STATS_EN to add the stall counter.

module fifo_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FIFO_DATAWIDTH = 16,
  parameter int MAX_BURST      = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              wr_clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*FIFO_DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              fifo_wr_en,
  output logic [FIFO_DATAWIDTH-1:0]         fifo_din,
  input  logic                              fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic                              stats_clr,
  output logic [CNT_WIDTH-1:0]              stall_cnt,
`endif
  output logic                              busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d, last_q, last_d, rr_pick, cand;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0][FIFO_DATAWIDTH-1:0] data_arr;

  assign data_arr = req_data;

  // Round-robin pick: scan from farthest to nearest after last owner so the
  // nearest valid requester is the final assignment and wins.
  always_comb begin
    rr_pick = owner_q;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand]) rr_pick = cand;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          owner_d = rr_pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req_valid[owner_q]) begin
          // owner went quiet: end the burst early
          state_d = IDLE;
          last_d  = owner_q;
        end else if (!fifo_full) begin
          cnt_d = cnt_q + BW'(1);
          if (cnt_q == BW'(MAX_BURST-1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
        // full with owner valid: stall, hold everything
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == GRANT);
  assign grant_id   = owner_q;
  assign fifo_wr_en = busy & req_valid[owner_q] & ~fifo_full;
  assign fifo_din   = data_arr[owner_q];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = busy & ~fifo_full & (owner_q == IDW'(i));
  end

`ifdef FIFO_ARB_STATS_EN
  logic stall;
  assign stall = busy & req_valid[owner_q] & fifo_full;

  // clear has priority over a same-cycle stall
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (stats_clr)               stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end
`endif

endmodule
